// File: rtl/trivium_host_if.sv
// Host-side initiator for the trivium_top serial interface: key/IV load, busy wait, word streaming.
// Optional busy-wait watchdog enabled by defining TRIVIUM_HOST_TIMEOUT_EN.
module trivium_host_if #(
   parameter int unsigned KEY_W          = 80,
   parameter int unsigned WORD_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic              clk_i,
   input  logic              n_rst_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [KEY_W-1:0]  key_i,
   input  logic [KEY_W-1:0]  iv_i,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   input  logic [WORD_W-1:0] word_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [WORD_W-1:0] res_o,
   input  logic              done_i,
   output logic              err_o,
   output logic              cor_dat_o,
   output logic              cor_init_o,
   output logic              cor_end_o,
   input  logic              cor_dat_i,
   input  logic              cor_busy_i
);

   localparam int unsigned CNT_W = 7;
   localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_W - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_WAKE, S_SEND_IV, S_SEND_KEY, S_INIT, S_WAIT_INIT,
      S_READY, S_PRIME, S_SHIFT, S_OUT, S_END
   } state_t;

   state_t              state, nxt_state;
   logic [CNT_W-1:0]    cnt, nxt_cnt;
   logic [KEY_W-1:0]    iv_sr, nxt_iv, key_sr, nxt_key;
   logic [WORD_W-1:0]   dat_sr, nxt_dat, res_sr, nxt_res_sr, nxt_res;
   logic                tmo_hit;
   logic                nxt_cfg_ready, nxt_word_ready, nxt_res_valid, nxt_err;
   logic                nxt_cor_dat, nxt_cor_init, nxt_cor_end;

`ifdef TRIVIUM_HOST_TIMEOUT_EN
   localparam int unsigned TMO_W = 13;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_W-1:0]    tmo_cnt, nxt_tmo;
`endif

   // Next-state, datapath and output decode; outputs are registered from the next state
   always_comb begin
      nxt_state  = state;
      nxt_cnt    = cnt;
      nxt_iv     = iv_sr;
      nxt_key    = key_sr;
      nxt_dat    = dat_sr;
      nxt_res_sr = res_sr;
      nxt_res    = res_o;
      tmo_hit    = 1'b0;
`ifdef TRIVIUM_HOST_TIMEOUT_EN
      nxt_tmo    = tmo_cnt;
`endif
      case (state)
         S_IDLE: begin
            if (cfg_ready_o && cfg_valid_i) begin
               nxt_iv    = iv_i;
               nxt_key   = key_i;
               nxt_state = S_WAKE;
            end
         end
         S_WAKE: begin
            nxt_cnt   = '0;
            nxt_state = S_SEND_IV;
         end
         S_SEND_IV: begin
            nxt_iv = iv_sr >> 1;
            if (cnt == KEY_LAST) begin
               nxt_cnt   = '0;
               nxt_state = S_SEND_KEY;
            end else begin
               nxt_cnt = cnt + 1'b1;
            end
         end
         S_SEND_KEY: begin
            nxt_key = key_sr >> 1;
            if (cnt == KEY_LAST) begin
               nxt_cnt   = '0;
               nxt_state = S_INIT;
            end else begin
               nxt_cnt = cnt + 1'b1;
            end
         end
         S_INIT: begin
`ifdef TRIVIUM_HOST_TIMEOUT_EN
            nxt_tmo = '0;
`endif
            nxt_state = S_WAIT_INIT;
         end
         S_WAIT_INIT: begin
            if (!cor_busy_i) begin
               nxt_state = S_READY;
            end
`ifdef TRIVIUM_HOST_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
               tmo_hit   = 1'b1;
               nxt_state = S_IDLE;
            end else begin
               nxt_tmo = tmo_cnt + 1'b1;
            end
`endif
         end
         S_READY: begin
            // A word wins over a simultaneous end-of-session request
            if (word_valid_i) begin
               nxt_dat   = word_i;
               nxt_state = S_PRIME;
            end else if (done_i) begin
               nxt_state = S_END;
            end
         end
         S_PRIME: begin
            nxt_cnt   = '0;
            nxt_state = S_SHIFT;
         end
         S_SHIFT: begin
            nxt_dat    = dat_sr >> 1;
            nxt_res_sr = {cor_dat_i, res_sr[WORD_W-1:1]};
            if (cnt == WORD_LAST) begin
               nxt_res   = nxt_res_sr;
               nxt_cnt   = '0;
               nxt_state = S_OUT;
            end else begin
               nxt_cnt = cnt + 1'b1;
            end
         end
         S_OUT: begin
            if (res_ready_i) nxt_state = S_READY;
         end
         S_END: begin
            nxt_state = S_IDLE;
         end
         default: begin
            nxt_state = S_IDLE;
         end
      endcase

      nxt_cfg_ready  = (nxt_state == S_IDLE);
      nxt_word_ready = (nxt_state == S_READY);
      nxt_res_valid  = (nxt_state == S_OUT);
      nxt_err        = tmo_hit && (TIMEOUT_CYCLES != 0);
      nxt_cor_end    = (nxt_state == S_END) || tmo_hit;
      nxt_cor_init   = (nxt_state == S_WAKE) || (nxt_state == S_SEND_IV) ||
                       (nxt_state == S_SEND_KEY) || (nxt_state == S_INIT) ||
                       (nxt_state == S_PRIME) || (nxt_state == S_SHIFT);
      case (nxt_state)
         S_SEND_IV:         nxt_cor_dat = nxt_iv[0];
         S_SEND_KEY:        nxt_cor_dat = nxt_key[0];
         S_PRIME, S_SHIFT:  nxt_cor_dat = nxt_dat[0];
         default:           nxt_cor_dat = 1'b0;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk_i) begin
      if (!n_rst_i) begin
         state        <= S_IDLE;
         cnt          <= '0;
         iv_sr        <= '0;
         key_sr       <= '0;
         dat_sr       <= '0;
         res_sr       <= '0;
         res_o        <= '0;
         cfg_ready_o  <= 1'b0;
         word_ready_o <= 1'b0;
         res_valid_o  <= 1'b0;
         err_o        <= 1'b0;
         cor_dat_o    <= 1'b0;
         cor_init_o   <= 1'b0;
         cor_end_o    <= 1'b0;
`ifdef TRIVIUM_HOST_TIMEOUT_EN
         tmo_cnt      <= '0;
`endif
      end else begin
         state        <= nxt_state;
         cnt          <= nxt_cnt;
         iv_sr        <= nxt_iv;
         key_sr       <= nxt_key;
         dat_sr       <= nxt_dat;
         res_sr       <= nxt_res_sr;
         res_o        <= nxt_res;
         cfg_ready_o  <= nxt_cfg_ready;
         word_ready_o <= nxt_word_ready;
         res_valid_o  <= nxt_res_valid;
         err_o        <= nxt_err;
         cor_dat_o    <= nxt_cor_dat;
         cor_init_o   <= nxt_cor_init;
         cor_end_o    <= nxt_cor_end;
`ifdef TRIVIUM_HOST_TIMEOUT_EN
         tmo_cnt      <= nxt_tmo;
`endif
      end
   end

endmodule

// File: tb/tb_trivium_host_if.sv
// Directed bench for trivium_host_if: load timing, loopback words, back-pressure, reset abort, end.
module tb_trivium_host_if;

   logic        clk = 1'b0;
   logic        n_rst, cfg_valid, word_valid, res_ready, done, cor_busy;
   logic [79:0] key, iv;
   logic [31:0] word, res;
   logic        cfg_ready, word_ready, res_valid, err, cor_dat, cor_init, cor_end;
   int          passed = 0;
   int          total  = 0;
   int          hi, ones, first, lat;

   always #5 clk = ~clk;

   // Core modelled as a wire loop: serial output echoes serial input
   trivium_host_if dut (
      .clk_i        (clk),
      .n_rst_i      (n_rst),
      .cfg_valid_i  (cfg_valid),
      .cfg_ready_o  (cfg_ready),
      .key_i        (key),
      .iv_i         (iv),
      .word_valid_i (word_valid),
      .word_ready_o (word_ready),
      .word_i       (word),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .res_o        (res),
      .done_i       (done),
      .err_o        (err),
      .cor_dat_o    (cor_dat),
      .cor_init_o   (cor_init),
      .cor_end_o    (cor_end),
      .cor_dat_i    (cor_dat),
      .cor_busy_i   (cor_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Present key/IV, then profile the init strobe: cycles high, data ones, index of first one
   task automatic load_cfg(input logic [79:0] k, input logic [79:0] v,
                           output int n_hi, output int n_ones, output int first_one);
      key = k;
      iv = v;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      n_hi = 0;
      n_ones = 0;
      first_one = -1;
      while (cor_init && n_hi < 300) begin
         if (cor_dat) begin
            n_ones++;
            if (first_one < 0) first_one = n_hi;
         end
         n_hi++;
         @(negedge clk);
      end
   endtask

   task automatic run_word(input logic [31:0] w, output int n);
      word = w;
      word_valid = 1'b1;
      @(negedge clk);
      word_valid = 1'b0;
      n = 1;
      while (!res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      n_rst = 1'b0; cfg_valid = 1'b0; word_valid = 1'b0; res_ready = 1'b0;
      done = 1'b0; cor_busy = 1'b0; key = '0; iv = '0; word = '0;
      repeat (2) @(negedge clk);
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("rst_word_ready", 32'(word_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res", res, 32'h0);
      chk("rst_strobes", {29'd0, cor_init, cor_end, cor_dat}, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      n_rst = 1'b1;
      @(negedge clk);
      chk("idle_cfg_ready", 32'(cfg_ready), 32'd1);

      // key=0, iv=1, busy for 20 wait cycles
      cor_busy = 1'b1;
      load_cfg(80'h0, 80'h1, hi, ones, first);
      chk("t1_init_cycles", 32'(hi), 32'd162);
      chk("t1_dat_ones", 32'(ones), 32'd1);
      chk("t1_first_dat_idx", 32'(first), 32'd1);
      chk("t1_cfg_ready_busy", 32'(cfg_ready), 32'd0);
      repeat (20) @(negedge clk);
      cor_busy = 1'b0;
      chk("t1_not_ready_yet", 32'(word_ready), 32'd0);
      @(negedge clk);
      chk("t1_ready_after_busy", 32'(word_ready), 32'd1);

      // loopback single word
      run_word(32'hDEADBEEF, lat);
      chk("t2_latency", 32'(lat), 32'd34);
      chk("t2_res", res, 32'hDEADBEEF);
      chk("t2_word_ready_out", 32'(word_ready), 32'd0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("t2_res_valid_drop", 32'(res_valid), 32'd0);
      chk("t2_back_ready", 32'(word_ready), 32'd1);

      // back-to-back with held result; done_i alongside the second word must lose
      run_word(32'h00000001, lat);
      chk("t3_latency0", 32'(lat), 32'd34);
      chk("t3_res0", res, 32'h00000001);
      word = 32'h80000000;
      word_valid = 1'b1;
      done = 1'b1;
      repeat (5) @(negedge clk);
      chk("t3_hold_word_ready", 32'(word_ready), 32'd0);
      chk("t3_hold_res_valid", 32'(res_valid), 32'd1);
      chk("t3_hold_end", 32'(cor_end), 32'd0);
      chk("t3_hold_res", res, 32'h00000001);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("t3_ready_again", 32'(word_ready), 32'd1);
      @(negedge clk);
      word_valid = 1'b0;
      done = 1'b0;
      chk("t3_prime_init", 32'(cor_init), 32'd1);
      chk("t3_prime_no_end", 32'(cor_end), 32'd0);
      lat = 1;
      while (!res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("t3_latency1", 32'(lat), 32'd34);
      chk("t3_res1", res, 32'h80000000);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;

      // end of session
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("t5_end_pulse", 32'(cor_end), 32'd1);
      chk("t5_cfg_ready_during_end", 32'(cfg_ready), 32'd0);
      @(negedge clk);
      chk("t5_end_one_cycle", 32'(cor_end), 32'd0);
      chk("t5_cfg_ready_after", 32'(cfg_ready), 32'd1);

      // reset at SEND_KEY bit 40; key has only bit 40 set
      key = 80'd1 << 40;
      iv = '0;
      cor_busy = 1'b1;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (121) @(negedge clk);
      chk("t4_key_bit40_init", 32'(cor_init), 32'd1);
      chk("t4_key_bit40_dat", 32'(cor_dat), 32'd1);
      n_rst = 1'b0;
      @(negedge clk);
      chk("t4_rst_strobes", {29'd0, cor_init, cor_end, cor_dat}, 32'd0);
      chk("t4_rst_readies", {29'd0, cfg_ready, word_ready, res_valid}, 32'd0);
      chk("t4_rst_res", res, 32'h0);
      chk("t4_rst_err", 32'(err), 32'd0);
      n_rst = 1'b1;
      @(negedge clk);
      chk("t4_cfg_ready", 32'(cfg_ready), 32'd1);
      load_cfg({80{1'b1}}, 80'h0, hi, ones, first);
      chk("t4_init_cycles", 32'(hi), 32'd162);
      chk("t4_dat_ones", 32'(ones), 32'd80);
      chk("t4_first_key_idx", 32'(first), 32'd81);
      repeat (3) @(negedge clk);
      cor_busy = 1'b0;
      @(negedge clk);
      chk("t4_ready", 32'(word_ready), 32'd1);
      run_word(32'h12345678, lat);
      chk("t4_latency", 32'(lat), 32'd34);
      chk("t4_res", res, 32'h12345678);
      chk("no_err", 32'(err), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
